// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_ctrl
//  Purpose  : Single-port byte RAM with a 2-bit command decoder, fed by the
//             words an SPI slave receives. Read data is handed back to the
//             SPI slave and held valid for TX_HOLD cycles so it can be
//             serialised on MISO.
//  Ports    : clk       - system clock, rising edge
//             rst       - synchronous active-high reset
//             rx_valid  - one-cycle strobe, din holds a complete word
//             din[9:0]  - [9:8] opcode, [7:0] address or data payload
//             dout[7:0] - read data towards the SPI slave
//             tx_valid  - dout valid, high for exactly TX_HOLD cycles
//             cmd_err   - one-cycle pulse for a rejected command
//  Opcodes  : 00 write address, 01 write data, 10 read address, 11 read data
//  Options  : SPI_RAM_AUTO_INC_EN - when defined, the write address advances
//             after each accepted write-data command and the read address
//             after each accepted read-data command (both wrap at
//             MEM_DEPTH-1), enabling burst transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int TX_HOLD   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [9:0] din,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       cmd_err
);

   localparam logic [1:0]           OP_WR_ADDR  = 2'b00;
   localparam logic [1:0]           OP_WR_DATA  = 2'b01;
   localparam logic [1:0]           OP_RD_ADDR  = 2'b10;
   localparam logic [1:0]           OP_RD_DATA  = 2'b11;
   localparam logic [7:0]           HOLD_RELOAD = 8'(TX_HOLD - 1);
`ifdef SPI_RAM_AUTO_INC_EN
   localparam logic [ADDR_SIZE-1:0] ADDR_LAST   = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_TX   = 1'b1
   } state_t;

   logic [7:0]           mem [0:MEM_DEPTH-1];

   state_t               state_q,   state_d;
   logic [7:0]           dout_q,    dout_d;
   logic                 cmd_err_q, cmd_err_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 wr_ok_q,   wr_ok_d;
   logic                 rd_ok_q,   rd_ok_d;
   logic [7:0]           hold_q,    hold_d;

   logic                 w_mem_we;
   logic [1:0]           w_op;
   logic [7:0]           w_payload;
   logic                 w_in_range;

   assign w_op       = din[9:8];
   assign w_payload  = din[7:0];
   assign w_in_range = (int'(w_payload) < MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
   function automatic logic [ADDR_SIZE-1:0] f_next_addr(input logic [ADDR_SIZE-1:0] a);
      return (a == ADDR_LAST) ? '0 : a + ADDR_SIZE'(1);
   endfunction
`endif

   // --------------------------------------------------------------------
   // Next-state / command decode
   // --------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      cmd_err_d = 1'b0;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      wr_ok_d   = wr_ok_q;
      rd_ok_d   = rd_ok_q;
      hold_d    = hold_q;
      w_mem_we  = 1'b0;

      // Hold countdown; a read-data command below overrides it (reload).
      case (state_q)
         S_TX: begin
            if (hold_q == 8'd0) state_d = S_IDLE;
            else                hold_d  = hold_q - 8'd1;
         end
         default: ;
      endcase

      if (rx_valid) begin
         case (w_op)
            OP_WR_ADDR: begin
               if (w_in_range) begin
                  wr_addr_d = w_payload;
                  wr_ok_d   = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            OP_WR_DATA: begin
               if (wr_ok_q) begin
                  w_mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                  wr_addr_d = f_next_addr(wr_addr_q);
`endif
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            OP_RD_ADDR: begin
               if (w_in_range) begin
                  rd_addr_d = w_payload;
                  rd_ok_d   = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            OP_RD_DATA: begin
               if (rd_ok_q) begin
                  // Read uses the address before any auto-increment.
                  dout_d  = mem[rd_addr_q];
                  state_d = S_TX;
                  hold_d  = HOLD_RELOAD;
`ifdef SPI_RAM_AUTO_INC_EN
                  rd_addr_d = f_next_addr(rd_addr_q);
`endif
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dout_q    <= 8'd0;
         cmd_err_q <= 1'b0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         wr_ok_q   <= 1'b0;
         rd_ok_q   <= 1'b0;
         hold_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         dout_q    <= dout_d;
         cmd_err_q <= cmd_err_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         wr_ok_q   <= wr_ok_d;
         rd_ok_q   <= rd_ok_d;
         hold_q    <= hold_d;
      end
   end

   // RAM array is deliberately not reset; reset only blocks the write.
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) mem[wr_addr_q] <= w_payload;
   end

   assign dout     = dout_q;
   assign tx_valid = (state_q == S_TX);
   assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_ctrl
//  Purpose  : Self-checking bench for spi_ram_ctrl. Directed command
//             sequences followed by random traffic, compared each cycle
//             against a command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

   localparam int DEPTH = 200;
   localparam int HOLD  = 9;
`ifdef SPI_RAM_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [9:0] din = 10'd0;
   logic [7:0] dout;
   logic       tx_valid;
   logic       cmd_err;

   spi_ram_ctrl #(
      .MEM_DEPTH (DEPTH),
      .ADDR_SIZE (8),
      .TX_HOLD   (HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .din      (din),
      .dout     (dout),
      .tx_valid (tx_valid),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] m_mem [0:255];
   int         m_wa, m_ra, m_rem;
   bit         m_wok, m_rok, m_err;
   logic [7:0] m_dout;

   int n_vec = 0;
   int n_err = 0;
   int tx_cnt;

   task automatic model_edge(input logic r, input logic v, input logic [9:0] w);
      bit reload;
      int p;
      reload = 1'b0;
      p      = int'(w[7:0]);
      if (r) begin
         m_dout = 8'd0; m_rem = 0; m_err = 1'b0;
         m_wa = 0; m_ra = 0; m_wok = 1'b0; m_rok = 1'b0;
         return;
      end
      m_err = 1'b0;
      if (v) begin
         case (w[9:8])
            2'b00: if (p < DEPTH) begin m_wa = p; m_wok = 1'b1; end else m_err = 1'b1;
            2'b01: if (m_wok) begin
                      m_mem[m_wa] = w[7:0];
                      if (AUTO) m_wa = (m_wa + 1) % DEPTH;
                   end else m_err = 1'b1;
            2'b10: if (p < DEPTH) begin m_ra = p; m_rok = 1'b1; end else m_err = 1'b1;
            default: if (m_rok) begin
                      m_dout = m_mem[m_ra];
                      m_rem  = HOLD;
                      reload = 1'b1;
                      if (AUTO) m_ra = (m_ra + 1) % DEPTH;
                   end else m_err = 1'b1;
         endcase
      end
      if (!reload && m_rem > 0) m_rem = m_rem - 1;
   endtask

   task automatic check(input string tag);
      n_vec++;
      assert (dout === m_dout) else begin
         n_err++;
         $error("FAIL %s dout: observed %h expected %h", tag, dout, m_dout);
      end
      n_vec++;
      assert (tx_valid === (m_rem > 0)) else begin
         n_err++;
         $error("FAIL %s tx_valid: observed %b expected %b", tag, tx_valid, (m_rem > 0));
      end
      n_vec++;
      assert (cmd_err === m_err) else begin
         n_err++;
         $error("FAIL %s cmd_err: observed %b expected %b", tag, cmd_err, m_err);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [9:0] w, input string tag);
      rst      = r;
      rx_valid = v;
      din      = w;
      @(posedge clk);
      model_edge(r, v, w);
      #1;
      check(tag);
      rst      = 1'b0;
      rx_valid = 1'b0;
   endtask

   initial begin
      // Reset held for two cycles
      step(1'b1, 1'b0, 10'h000, "reset");
      step(1'b1, 1'b0, 10'h000, "reset");
      n_vec++;
      assert (dout === 8'h00 && tx_valid === 1'b0 && cmd_err === 1'b0) else begin
         n_err++;
         $error("FAIL reset_state: observed %h/%b/%b expected 00/0/0", dout, tx_valid, cmd_err);
      end

      // Read data with no read address -> error, no tx
      step(1'b0, 1'b1, 10'h300, "rd_noaddr");
      n_vec++;
      assert (cmd_err === 1'b1 && tx_valid === 1'b0) else begin
         n_err++;
         $error("FAIL rd_noaddr: observed err=%b tx=%b expected err=1 tx=0", cmd_err, tx_valid);
      end
      step(1'b0, 1'b0, 10'h000, "err_clear");
      step(1'b0, 1'b1, 10'h155, "wd_noaddr");
      step(1'b0, 1'b0, 10'h000, "idle");

      // Preload the whole RAM so every later read has a known value
      for (int a = 0; a < DEPTH; a++) begin
         step(1'b0, 1'b1, {2'b00, 8'(a)}, "pre_wa");
         step(1'b0, 1'b1, {2'b01, (a == 0) ? 8'hA5 : 8'($urandom)}, "pre_wd");
      end

      // Rejected write after reset must not reach address 0
      step(1'b1, 1'b0, 10'h000, "reset2");
      step(1'b0, 1'b1, 10'h155, "wd_noaddr2");
      step(1'b0, 1'b1, 10'h200, "ra0");
      step(1'b0, 1'b1, 10'h300, "rd0");
      n_vec++;
      assert (dout === 8'hA5) else begin
         n_err++;
         $error("FAIL rd0_unwritten: observed %h expected a5", dout);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 10'h000, "rd0_hold");

      // Basic write / read with hold length measurement
      step(1'b0, 1'b1, 10'h00A, "wa_0a");
      step(1'b0, 1'b1, 10'h155, "wd_55");
      step(1'b0, 1'b1, 10'h20A, "ra_0a");
      step(1'b0, 1'b1, 10'h300, "rd_0a");
      n_vec++;
      assert (dout === 8'h55 && tx_valid === 1'b1) else begin
         n_err++;
         $error("FAIL rd_0a: observed %h/%b expected 55/1", dout, tx_valid);
      end
      tx_cnt = 1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 10'h000, "hold");
         if (tx_valid) tx_cnt++;
      end
      n_vec++;
      assert (tx_cnt === HOLD) else begin
         n_err++;
         $error("FAIL hold_len: observed %0d expected %0d", tx_cnt, HOLD);
      end

      // Address range boundary
      step(1'b0, 1'b1, 10'h010, "wa_10");
      step(1'b0, 1'b1, 10'h0C8, "wa_200");
      n_vec++;
      assert (cmd_err === 1'b1) else begin
         n_err++;
         $error("FAIL wa_200: observed err=%b expected 1", cmd_err);
      end
      step(1'b0, 1'b1, 10'h199, "wd_99");
      step(1'b0, 1'b1, 10'h2C8, "ra_200");
      step(1'b0, 1'b1, 10'h2FF, "ra_255");
      step(1'b0, 1'b1, 10'h0C7, "wa_199");
      n_vec++;
      assert (cmd_err === 1'b0) else begin
         n_err++;
         $error("FAIL wa_199: observed err=%b expected 0", cmd_err);
      end
      step(1'b0, 1'b1, 10'h177, "wd_77");
      step(1'b0, 1'b1, 10'h210, "ra_10");
      step(1'b0, 1'b1, 10'h300, "rd_10");
      step(1'b0, 1'b1, 10'h2C7, "ra_199");
      step(1'b0, 1'b1, 10'h300, "rd_199");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 10'h000, "idle");

      // Reload during hold, then reset mid-hold
      step(1'b0, 1'b1, 10'h00B, "wa_0b");
      step(1'b0, 1'b1, 10'h13C, "wd_3c");
      step(1'b0, 1'b1, 10'h20A, "ra_0a");
      step(1'b0, 1'b1, 10'h300, "rd_first");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 10'h000, "hold1");
      step(1'b0, 1'b1, 10'h20B, "ra_0b");
      step(1'b0, 1'b1, 10'h300, "rd_reload");
      n_vec++;
      assert (dout === 8'h3C && tx_valid === 1'b1) else begin
         n_err++;
         $error("FAIL rd_reload: observed %h/%b expected 3c/1", dout, tx_valid);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'h000, "hold2");
      step(1'b1, 1'b0, 10'h000, "rst_mid");
      n_vec++;
      assert (tx_valid === 1'b0) else begin
         n_err++;
         $error("FAIL rst_mid: observed tx=%b expected 0", tx_valid);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'h000, "idle");

      // Burst at the top of the address range (model covers both builds)
      step(1'b0, 1'b1, {2'b00, 8'(DEPTH - 1)}, "b_wa");
      step(1'b0, 1'b1, 10'h111, "b_wd11");
      step(1'b0, 1'b1, 10'h122, "b_wd22");
      step(1'b0, 1'b1, {2'b10, 8'(DEPTH - 1)}, "b_ra");
      step(1'b0, 1'b1, 10'h300, "b_rd1");
      step(1'b0, 1'b0, 10'h000, "b_gap");
      step(1'b0, 1'b1, 10'h300, "b_rd2");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 10'h000, "idle");

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 1023)), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
